// File: rtl/processor_mc_core.sv
// processor_mc_core: multi-cycle 32-bit ISA core (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with req/ack instruction and data memory ports and a retired-instruction counter.
module processor_mc_core #(
  parameter int N = 32,
  parameter int AW = 10,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          unstop,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [N-1:0]  dmem_wdata,
  input  logic          dmem_ack,
  input  logic [N-1:0]  dmem_rdata,
  output logic          halted,
  output logic [N-1:0]  retired
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h01, OP_LD = 6'h02, OP_ST = 6'h03;
  localparam logic [5:0] OP_BZ = 6'h04, OP_BNZ = 6'h05, OP_J = 6'h06, OP_HALT = 6'h3F;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [N-1:0]  ret_q, ret_d;
  logic [N-1:0]  a_q, b_q, alu_q, md_q;
  logic [N-1:0]  rf_q [32];
  logic          run_q;
  logic [5:0]    op;
  logic [4:0]    rs, rt, rd, wb_idx;
  logic [3:0]    fn;
  logic [N-1:0]  simm, r_res, alu_res;
  logic          taken, wb_en, is_br;
  assign op = ir_q[31:26];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign fn = ir_q[3:0];
  assign simm = N'($signed(ir_q[15:0]));
  assign alu_res = (op == OP_R) ? r_res : a_q + simm;
  assign taken = (op == OP_BZ && a_q == '0) || (op == OP_BNZ && a_q != '0);
  assign is_br = op == OP_BZ || op == OP_BNZ || op == OP_J;
  assign wb_en = (op == OP_R && fn <= 4'd8) || op == OP_ADDI || op == OP_LD;
  assign wb_idx = (op == OP_R) ? rd : rt;
  // run_q keeps imem_req low for the cycle right after a reset edge
  assign imem_req = state_q == S_FETCH && run_q;
  assign imem_addr = pc_q;
  assign dmem_req = state_q == S_MEM;
  assign dmem_we = op == OP_ST;
  assign dmem_addr = alu_q[AW-1:0];
  assign dmem_wdata = b_q;
  assign halted = state_q == S_HALT;
  assign retired = ret_q;
  always_comb begin
    case (fn)
      4'd0: r_res = a_q + b_q;
      4'd1: r_res = a_q - b_q;
      4'd2: r_res = a_q & b_q;
      4'd3: r_res = a_q | b_q;
      4'd4: r_res = a_q ^ b_q;
      4'd5: r_res = a_q << b_q[4:0];
      4'd6: r_res = a_q >> b_q[4:0];
      4'd7: r_res = $signed(a_q) >>> b_q[4:0];
      default: r_res = {{(N-1){1'b0}}, $signed(a_q) < $signed(b_q)};
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    ret_d = ret_q;
    case (state_q)
      S_FETCH: if (imem_req && imem_ack) begin
        ir_d = imem_rdata;
        pc_d = pc_q + AW'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
        ret_d = (op == OP_HALT) ? ret_q + N'(1) : ret_q;
      end
      S_EXEC: if (is_br) begin
        pc_d = (op == OP_J) ? pc_q + AW'($signed(ir_q[25:0])) :
               taken ? pc_q + AW'($signed(ir_q[15:0])) : pc_q;
        ret_d = ret_q + N'(1);
        state_d = S_FETCH;
      end else begin
        state_d = (op == OP_LD || op == OP_ST) ? S_MEM : S_WB;
      end
      S_MEM: if (dmem_ack) begin
        state_d = dmem_we ? S_FETCH : S_WB;
        ret_d = dmem_we ? ret_q + N'(1) : ret_q;
      end
      S_WB: begin
        state_d = S_FETCH;
        ret_d = ret_q + N'(1);
      end
      S_HALT: state_d = unstop ? S_FETCH : S_HALT;
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      ir_q <= '0;
      ret_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_q <= '0;
      md_q <= '0;
      run_q <= 1'b0;
      rf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      ret_q <= ret_d;
      run_q <= 1'b1;
      if (state_q == S_DECODE) begin
        a_q <= (rs == 5'd0) ? '0 : rf_q[rs];
        b_q <= (rt == 5'd0) ? '0 : rf_q[rt];
      end
      if (state_q == S_EXEC) alu_q <= alu_res;
      if (state_q == S_MEM && dmem_ack) md_q <= dmem_rdata;
      if (state_q == S_WB && wb_en && wb_idx != 5'd0) rf_q[wb_idx] <= (op == OP_LD) ? md_q : alu_q;
    end
  end
endmodule

// File: tb/tb_processor_mc_core.sv
// tb_processor_mc_core: directed programs against an instruction-level model of the ISA,
// with bench-side memories that insert configurable wait states.
module tb_processor_mc_core;
  localparam int N = 32;
  localparam int AW = 10;
  logic clk = 0, rst = 0, unstop = 0;
  logic imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0, halted;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0] imem_rdata = 0;
  logic [N-1:0] dmem_wdata, dmem_rdata = 0, retired;
  logic [31:0] imem_mem [1024];
  logic [31:0] dmem_mem [1024];
  int iw = 0, dw = 0, icnt = 0, dcnt = 0, cyc = 0;
  int tests = 0, fails = 0;
  logic [AW-1:0] m_pc = 0, m_daddr = 0;
  logic [31:0] m_rf [32];
  logic [31:0] m_cnt = 0, m_dwdata = 0;
  logic m_dwe = 0;
  bit m_halt = 0, prev_rst_low = 1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  processor_mc_core #(.N(N), .AW(AW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .unstop(unstop),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .retired(retired)
  );
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 7'd0, 4'(fn)};
  endfunction
  localparam logic [31:0] HALT = {6'h3F, 26'd0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic m_wr(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 0) m_rf[idx] = v;
  endtask
  task automatic m_reset();
    m_pc = 0;
    m_cnt = 0;
    m_halt = 0;
    m_dwe = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask
  // executes one instruction architecturally, at the moment it is fetched
  task automatic m_step(input logic [31:0] ins);
    logic [31:0] a, b, si, res;
    a = m_rf[ins[25:21]];
    b = m_rf[ins[20:16]];
    si = {{16{ins[15]}}, ins[15:0]};
    m_pc = m_pc + 10'd1;
    m_cnt = m_cnt + 1;
    case (ins[31:26])
      6'h00: if (ins[3:0] <= 4'd8) begin
        case (ins[3:0])
          4'd0: res = a + b;
          4'd1: res = a - b;
          4'd2: res = a & b;
          4'd3: res = a | b;
          4'd4: res = a ^ b;
          4'd5: res = a << b[4:0];
          4'd6: res = a >> b[4:0];
          4'd7: res = 32'($signed(a) >>> b[4:0]);
          default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        m_wr(ins[15:11], res);
      end
      6'h01: m_wr(ins[20:16], a + si);
      6'h02: begin
        m_daddr = AW'(a + si);
        m_dwe = 0;
        m_wr(ins[20:16], dmem_mem[m_daddr]);
      end
      6'h03: begin
        m_daddr = AW'(a + si);
        m_dwe = 1;
        m_dwdata = b;
      end
      6'h04: if (a == 0) m_pc = m_pc + ins[AW-1:0];
      6'h05: if (a != 0) m_pc = m_pc + ins[AW-1:0];
      6'h06: m_pc = m_pc + ins[AW-1:0];
      6'h3F: m_halt = 1;
      default: ;
    endcase
  endtask
  // per-cycle compare, then memory responders, then model update for the coming edge
  always @(negedge clk) begin
    #1;
    if (prev_rst_low) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_halted", halted, 0);
      chk("rst_retired", retired, 0);
    end else begin
      if (imem_req) begin
        chk("fetch_addr", imem_addr, m_pc);
        chk("retired_at_fetch", retired, m_cnt);
        chk("fetch_not_halted", m_halt, 0);
      end
      if (dmem_req) begin
        chk("dmem_addr", dmem_addr, m_daddr);
        chk("dmem_we", dmem_we, m_dwe);
        if (m_dwe) chk("dmem_wdata", dmem_wdata, m_dwdata);
      end
      if (halted) begin
        chk("halted_model", m_halt, 1);
        chk("retired_halted", retired, m_cnt);
      end
    end
    imem_ack = 0;
    dmem_ack = 0;
    if (imem_req) begin
      if (icnt == iw) begin
        imem_ack = 1;
        icnt = 0;
        imem_rdata = imem_mem[imem_addr];
      end else icnt++;
    end else icnt = 0;
    if (dmem_req) begin
      if (dcnt == dw) begin
        dmem_ack = 1;
        dcnt = 0;
        if (!dmem_we) dmem_rdata = dmem_mem[dmem_addr];
        else if (rst) dmem_mem[dmem_addr] = dmem_wdata;
      end else dcnt++;
    end else dcnt = 0;
    if (!rst) m_reset();
    else begin
      if (imem_ack) m_step(imem_mem[imem_addr]);
      if (halted && unstop) m_halt = 0;
    end
    prev_rst_low = !rst;
  end
  task automatic apply_rst();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1;
  endtask
  task automatic wait_halt(input string name, output int c);
    c = 0;
    do begin
      @(negedge clk);
      #2;
      c++;
    end while (!halted && c < 2000);
    if (!halted) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, halted %b expected 1", name, halted);
    end
  endtask
  task automatic wait_fetch(input string name, input int addr, output int t);
    bit found;
    found = 0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      #2;
      found = imem_req && imem_addr == AW'(addr);
    end
    t = cyc;
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, no fetch of %0d", name, addr);
    end
  endtask
  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), dut.rf_q[i], m_rf[i]);
  endtask
  initial begin
    int c, t0, t1, t2, t3;
    for (int i = 0; i < 1024; i++) begin
      imem_mem[i] = HALT;
      dmem_mem[i] = 0;
    end
    m_reset();
    repeat (3) @(negedge clk);
    #2;
    chk("init_imem_req", imem_req, 0);
    chk("init_dmem_req", dmem_req, 0);
    chk("init_halted", halted, 0);
    chk("init_retired", retired, 0);
    // basic ALU program, zero-wait memories
    imem_mem[0] = enc_i(1, 0, 1, 16'd5);
    imem_mem[1] = enc_i(1, 0, 2, 16'hFFFD);
    imem_mem[2] = enc_r(3, 1, 2, 0);
    imem_mem[3] = HALT;
    release_rst();
    wait_halt("t1_halt", c);
    chk("t1_halt_edges", c - 1, 14);
    chk("t1_r3", dut.rf_q[3], 32'd2);
    chk("t1_retired", retired, 4);
    check_regs("t1");
    // store then load with 3 data wait cycles
    apply_rst();
    dw = 3;
    dmem_mem[16] = 32'hDEAD;
    imem_mem[0] = enc_i(1, 0, 1, 16'd5);
    imem_mem[1] = enc_i(3, 0, 1, 16'h10);
    imem_mem[2] = enc_i(2, 0, 4, 16'h10);
    imem_mem[3] = HALT;
    release_rst();
    wait_fetch("t2_f0", 0, t0);
    wait_fetch("t2_f1", 1, t1);
    wait_fetch("t2_f2", 2, t2);
    wait_fetch("t2_f3", 3, t3);
    chk("t2_alu_cycles", t1 - t0, 4);
    chk("t2_st_cycles", t2 - t1, 7);
    chk("t2_ld_cycles", t3 - t2, 8);
    wait_halt("t2_halt", c);
    chk("t2_r4", dut.rf_q[4], 32'd5);
    chk("t2_mem16", dmem_mem[16], 32'd5);
    check_regs("t2");
    // loop, fall-through branch, halt/resume, jump; one fetch wait cycle
    apply_rst();
    dw = 0;
    iw = 1;
    imem_mem[0] = enc_i(1, 0, 1, 16'd3);
    imem_mem[1] = enc_i(1, 1, 1, 16'hFFFF);
    imem_mem[2] = enc_i(5, 1, 0, 16'hFFFE);
    imem_mem[3] = enc_i(1, 0, 5, 16'd7);
    imem_mem[4] = enc_i(4, 5, 0, 16'd5);
    imem_mem[5] = HALT;
    imem_mem[6] = enc_i(1, 0, 6, 16'd9);
    imem_mem[7] = {6'h06, 26'd1};
    imem_mem[8] = enc_i(1, 0, 7, 16'd1);
    imem_mem[9] = HALT;
    release_rst();
    wait_fetch("t3_exit", 3, t0);
    chk("t3_retired_loop", retired, 7);
    chk("t3_r1", dut.rf_q[1], 0);
    wait_halt("t3_halt", c);
    chk("t3_retired_halt", retired, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      chk("t4_hold_halted", halted, 1);
      chk("t4_hold_noreq", imem_req, 0);
    end
    @(negedge clk);
    unstop = 1;
    @(negedge clk);
    unstop = 0;
    #2;
    chk("t4_resume_req", imem_req, 1);
    chk("t4_resume_addr", imem_addr, 6);
    @(negedge clk);
    unstop = 1;
    @(negedge clk);
    unstop = 0;
    wait_halt("t4_halt", c);
    chk("t4_r6", dut.rf_q[6], 32'd9);
    chk("t4_r7", dut.rf_q[7], 32'd0);
    chk("t4_retired", retired, 13);
    check_regs("t4");
    // R-type sweep, r0 write, NOP encodings
    apply_rst();
    iw = 2;
    dw = 1;
    imem_mem[0] = enc_i(1, 0, 1, 16'd1);
    imem_mem[1] = enc_i(1, 0, 2, 16'd31);
    imem_mem[2] = enc_r(1, 1, 2, 5);
    imem_mem[3] = enc_i(1, 0, 2, 16'd4);
    imem_mem[4] = enc_r(3, 1, 2, 7);
    imem_mem[5] = enc_r(4, 1, 2, 6);
    imem_mem[6] = enc_r(5, 1, 2, 8);
    imem_mem[7] = enc_r(0, 1, 2, 0);
    imem_mem[8] = enc_r(6, 2, 1, 1);
    imem_mem[9] = enc_r(7, 1, 2, 2);
    imem_mem[10] = enc_r(8, 1, 2, 3);
    imem_mem[11] = enc_r(9, 1, 2, 4);
    imem_mem[12] = enc_r(10, 1, 2, 9);
    imem_mem[13] = {6'h10, 5'd1, 5'd11, 16'h1234};
    imem_mem[14] = enc_i(3, 0, 3, 16'h20);
    imem_mem[15] = HALT;
    release_rst();
    wait_halt("t5_halt", c);
    chk("t5_sra", dut.rf_q[3], 32'hF800_0000);
    chk("t5_srl", dut.rf_q[4], 32'h0800_0000);
    chk("t5_slt", dut.rf_q[5], 32'd1);
    chk("t5_r0", dut.rf_q[0], 32'd0);
    chk("t5_sub", dut.rf_q[6], 32'h8000_0004);
    chk("t5_nop_funct", dut.rf_q[10], 32'd0);
    chk("t5_nop_op", dut.rf_q[11], 32'd0);
    chk("t5_store", dmem_mem[32], 32'hF800_0000);
    chk("t5_retired", retired, 16);
    check_regs("t5");
    // reset on the cycle the delayed fetch ack arrives
    apply_rst();
    iw = 5;
    dw = 0;
    imem_mem[0] = enc_i(1, 0, 1, 16'd5);
    imem_mem[1] = enc_i(1, 0, 2, 16'hFFFD);
    imem_mem[2] = enc_r(3, 1, 2, 0);
    imem_mem[3] = HALT;
    release_rst();
    wait_fetch("t6_f0", 0, t0);
    repeat (5) @(negedge clk);
    rst = 0;
    @(negedge clk);
    #2;
    chk("t6_req_dropped", imem_req, 0);
    chk("t6_retired", retired, 0);
    iw = 0;
    release_rst();
    wait_halt("t6_halt", c);
    chk("t6_halt_edges", c - 1, 14);
    chk("t6_r3", dut.rf_q[3], 32'd2);
    chk("t6_retired_end", retired, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1);
  end
endmodule

// File: doc/processor_mc_core.md
# processor_mc_core

Parametrised multi-cycle successor to the single-cycle processor top. It executes the team's 32-bit ISA subset through a five-phase state machine and talks to separate instruction and data memories over req/ack handshakes, so memories with wait states are supported. The core supports halt/resume through `unstop` and exposes a retired-instruction counter for bench checking.

## Interface
- `N`, 32, datapath and register width (≥16)
- `AW`, 10, word-address width of both memory ports
- `RESET_PC`, 0, PC value loaded on reset (AW bits)
- `clk`  input  1  single clock, all state updates on rising edge
- `rst`  input  1  reset; synchronous and active-low
- `unstop`  input  1  resume from HALT
- `imem_req`  output  1  instruction fetch request
- `imem_addr`  output  AW  fetch word address (= PC)
- `imem_ack`  input  1  fetch complete; `imem_rdata` valid this cycle
- `imem_rdata`  input  32  instruction word
- `dmem_req`  output  1  data access request
- `dmem_we`  output  1  1 = store, 0 = load
- `dmem_addr`  output  AW  data word address (ALU result [AW-1:0])
- `dmem_wdata`  output  N  store data (rt)
- `dmem_ack`  input  1  access complete; `dmem_rdata` valid this cycle
- `dmem_rdata`  input  N  load data
- `halted`  output  1  core is in HALT
- `retired`  output  N  count of completed instructions, wraps

## Operation
- Instruction fields: opcode IR[31:26], rs IR[25:21], rt IR[20:16], rd IR[15:11], funct IR[3:0], imm16 IR[15:0], imm26 IR[25:0]. Immediates are sign-extended to N bits.
- Opcodes:
  - 0x00 R-type: rd = rs op rt. funct 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt (signed). Shift amount is rt[4:0].
  - 0x01 ADDI: rt = rs + imm16.
  - 0x02 LD: rt = mem[rs + imm16].
  - 0x03 ST: mem[rs + imm16] = rt.
  - 0x04 BZ: if rs == 0, PC = PC + imm16.
  - 0x05 BNZ: if rs != 0, PC = PC + imm16.
  - 0x06 J: PC = PC + imm26.
  - 0x3F HALT.
  - All other opcodes, and funct > 8, retire as NOP.
- PC is a word address. Branch and jump targets are relative to the already-incremented PC. Arithmetic is modulo 2^AW for PC and 2^N for data.
- Register file: 32 × N bits. r0 always reads 0; writes to r0 are discarded.
- States:
  - FETCH: hold `imem_req`=1 and `imem_addr`=PC until `imem_ack`. On ack, latch IR, set PC ← PC+1, go to DECODE.
  - DECODE: read A=rs and B=rt. HALT goes to HALT; all others go to EXEC.
  - EXEC: ALU computes the result. Branches and jumps update PC and retire, then go to FETCH. LD/ST go to MEM; all others go to WB.
  - MEM: hold `dmem_req`, `dmem_addr`, `dmem_we` and `dmem_wdata` stable until `dmem_ack`. ST retires here and goes to FETCH; LD goes to WB.
  - WB: write the result (ALU result or load data). Go to FETCH.
  - HALT: `halted`=1. `retired` has already counted the HALT instruction. When `unstop`=1 is sampled, go to FETCH at the current PC (the instruction after HALT).
- `retired` increments by exactly 1 per instruction, at the edge leaving its final state.

## Timing
- Acks are sampled at the rising edge while req=1. An ack in the same cycle as req completes a zero-wait transfer. Ack while req=0 is ignored.
- Zero-wait latencies: ALU/NOP 4 cycles, LD 5, ST 4, branch/jump 3, HALT 2 (then remains in HALT).
- Each wait cycle of a memory adds exactly 1 cycle.
- Req deasserts in the cycle after ack. Two back-to-back instructions never keep `imem_req` low for fewer than 2 cycles.
- Reset values (rst=0 sampled at an edge): state FETCH, PC=RESET_PC, all registers 0, `retired`=0, `halted`=0, `imem_req`=0 and `dmem_req`=0 during the reset cycle.
- `imem_req` asserts in the first cycle after rst=1.
- Reset mid-transfer drops req immediately and the pending ack is ignored. A pending store is not retried.
- `unstop` outside HALT has no effect.
- A LD whose rt is read by the next instruction sees the new value; no hazards exist in a multi-cycle design.

## Test plan
- Reset then zero-wait memories, program `ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; HALT` -> r3 = 2, `halted`=1 at cycle 14 after reset release, `retired`=4.
- ST r1 → mem[0x10], then LD r4 ← mem[0x10], with `dmem_ack` delayed 3 cycles -> r4 = 5; `dmem_req`, `dmem_addr` and `dmem_wdata` stable throughout the wait; LD takes 8 cycles.
- Loop: r1=3; body `ADDI r1,r1,-1; BNZ r1,-2` -> exits with r1=0 after 3 iterations; `retired` = 1 + 6; the BZ not-taken path falls through to PC+1.
- HALT at PC 5; hold 10 cycles, then pulse `unstop` -> fetch resumes at `imem_addr`=6; `unstop` pulsed while running changes nothing.
- R-type sweep with rs=0x8000_0000, rt=4 -> sra 0xF800_0000, srl 0x0800_0000, slt 1; write to r0 leaves r0 = 0.
- Assert rst during a 5-cycle `imem_ack` wait -> next cycle `imem_req`=0; after release, fetch from RESET_PC, `retired`=0.
